apple_manager: RTL and testbench



---
 rtl/apple_manager.sv | 216 +++++++++++++++++++++
 tb/tb_apple_manager.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_manager.sv
// -----------------------------------------------------------------------------
// apple_manager
//
// Places the apple for the snake game and detects when the snake eats it.
// Candidate coordinates arrive every cycle from a free-running generator. The
// first legal candidate (inside the play field and not under the snake head)
// becomes the live apple. If too many candidates in a row are rejected, a fixed
// fallback position is used. When the head reaches the apple on a move tick,
// the block pulses eat, bumps a saturating 4-digit BCD score and re-places the
// apple.
//
// Ports:
//   VGA_CLK      in   1   sole clock, rising edge
//   reset        in   1   synchronous, active-high, dominates everything
//   start        in   1   one-cycle pulse, begins a game from IDLE
//   move_tick    in   1   one-cycle pulse when head_x/head_y take a new value
//   cand_x/y     in  10   candidate apple top-left from the generator
//   head_x/y     in  10   snake head top-left
//   apple_x/y    out 10   live apple top-left (holds while apple_valid=0)
//   apple_valid  out  1   apple placed and drawable
//   eat          out  1   one-cycle pulse per apple eaten
//   score_bcd    out 16   four BCD digits, [15:12] thousands
// -----------------------------------------------------------------------------
module apple_manager #(
    parameter int CELL       = 10,
    parameter int X_MIN      = 20,
    parameter int X_MAX      = 580,
    parameter int Y_MIN      = 20,
    parameter int Y_MAX      = 440,
    parameter int MAX_TRIES  = 64,
    parameter int FALLBACK_X = 320,
    parameter int FALLBACK_Y = 240
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        move_tick,
    input  logic [9:0]  cand_x,
    input  logic [9:0]  cand_y,
    input  logic [9:0]  head_x,
    input  logic [9:0]  head_y,
    output logic [9:0]  apple_x,
    output logic [9:0]  apple_y,
    output logic        apple_valid,
    output logic        eat,
    output logic [15:0] score_bcd
);

    localparam int          TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [10:0] CELL_W   = 11'(CELL);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLACE  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [9:0]       apple_x_r;
    logic [9:0]       apple_x_s;
    logic [9:0]       apple_y_r;
    logic [9:0]       apple_y_s;
    logic             apple_valid_r;
    logic             apple_valid_s;
    logic             eat_r;
    logic             eat_s;
    logic [15:0]      score_r;
    logic [15:0]      score_s;
    logic [TRY_W-1:0] try_r;
    logic [TRY_W-1:0] try_s;

    logic             cand_in_bounds_s;
    logic             cand_legal_s;
    logic             head_hit_s;

    // Square overlap test; operands widened to 11 bits so a+CELL cannot wrap.
    function automatic logic overlap(
        input logic [9:0] ax,
        input logic [9:0] ay,
        input logic [9:0] bx,
        input logic [9:0] by
    );
        logic [10:0] ax_w;
        logic [10:0] ay_w;
        logic [10:0] bx_w;
        logic [10:0] by_w;
        ax_w = {1'b0, ax};
        ay_w = {1'b0, ay};
        bx_w = {1'b0, bx};
        by_w = {1'b0, by};
        return (ax_w < (bx_w + CELL_W)) && (bx_w < (ax_w + CELL_W)) &&
               (ay_w < (by_w + CELL_W)) && (by_w < (ay_w + CELL_W));
    endfunction

    // Saturating BCD increment: ripple carry through the digits, hold at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        if (value == 16'h9999) begin
            result = value;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (result[i*4 +: 4] == 4'd9) begin
                        result[i*4 +: 4] = 4'd0;
                        carry            = 1'b1;
                    end else begin
                        result[i*4 +: 4] = result[i*4 +: 4] + 4'd1;
                        carry            = 1'b0;
                    end
                end else begin
                    carry = 1'b0;
                end
            end
        end
        return result;
    endfunction

    // Candidate legality and head-on-apple detection.
    always_comb begin
        cand_in_bounds_s = (cand_x >= 10'(X_MIN)) && (cand_x <= 10'(X_MAX)) &&
                           (cand_y >= 10'(Y_MIN)) && (cand_y <= 10'(Y_MAX));
        cand_legal_s     = cand_in_bounds_s && !overlap(cand_x, cand_y, head_x, head_y);
        head_hit_s       = overlap(head_x, head_y, apple_x_r, apple_y_r);
    end

    // Next-state and next-output logic for the placement/eat FSM.
    always_comb begin
        state_s       = state_r;
        apple_x_s     = apple_x_r;
        apple_y_s     = apple_y_r;
        apple_valid_s = apple_valid_r;
        eat_s         = 1'b0;
        score_s       = score_r;
        try_s         = try_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    score_s = 16'h0000;
                    try_s   = {TRY_W{1'b0}};
                    state_s = ST_PLACE;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_PLACE: begin
                if (cand_legal_s) begin
                    apple_x_s     = cand_x;
                    apple_y_s     = cand_y;
                    apple_valid_s = 1'b1;
                    try_s         = {TRY_W{1'b0}};
                    state_s       = ST_ACTIVE;
                end else if (try_r == TRY_LAST) begin
                    // Out of tries: use the fixed position without a head check.
                    apple_x_s     = 10'(FALLBACK_X);
                    apple_y_s     = 10'(FALLBACK_Y);
                    apple_valid_s = 1'b1;
                    try_s         = {TRY_W{1'b0}};
                    state_s       = ST_ACTIVE;
                end else begin
                    try_s = try_r + TRY_W'(1);
                end
            end

            ST_ACTIVE: begin
                if (move_tick && head_hit_s) begin
                    eat_s         = 1'b1;
                    apple_valid_s = 1'b0;
                    score_s       = bcd_inc(score_r);
                    state_s       = ST_PLACE;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end

            default: begin
                state_s       = ST_IDLE;
                apple_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            apple_x_r     <= 10'd0;
            apple_y_r     <= 10'd0;
            apple_valid_r <= 1'b0;
            eat_r         <= 1'b0;
            score_r       <= 16'h0000;
            try_r         <= {TRY_W{1'b0}};
        end else begin
            state_r       <= state_s;
            apple_x_r     <= apple_x_s;
            apple_y_r     <= apple_y_s;
            apple_valid_r <= apple_valid_s;
            eat_r         <= eat_s;
            score_r       <= score_s;
            try_r         <= try_s;
        end
    end

    assign apple_x     = apple_x_r;
    assign apple_y     = apple_y_r;
    assign apple_valid = apple_valid_r;
    assign eat         = eat_r;
    assign score_bcd   = score_r;

endmodule

// File: tb/tb_apple_manager.sv
// -----------------------------------------------------------------------------
// tb_apple_manager
//
// Directed and randomized stimulus for apple_manager. A behavioural model
// (integer score, phase number, plain arithmetic) is stepped at every rising
// edge and all outputs are compared against it one time unit later; directed
// steps add explicit constant checks at the interesting points.
// -----------------------------------------------------------------------------
module tb_apple_manager;

    logic        VGA_CLK = 1'b0;
    logic        reset;
    logic        start;
    logic        move_tick;
    logic [9:0]  cand_x;
    logic [9:0]  cand_y;
    logic [9:0]  head_x;
    logic [9:0]  head_y;
    logic [9:0]  apple_x;
    logic [9:0]  apple_y;
    logic        apple_valid;
    logic        eat;
    logic [15:0] score_bcd;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: phase 0 = idle, 1 = placing, 2 = apple live.
    int m_phase;
    int m_tries;
    int m_score;
    int m_ax;
    int m_ay;
    bit m_valid;
    bit m_eat;

    apple_manager dut (
        .VGA_CLK     (VGA_CLK),
        .reset       (reset),
        .start       (start),
        .move_tick   (move_tick),
        .cand_x      (cand_x),
        .cand_y      (cand_y),
        .head_x      (head_x),
        .head_y      (head_y),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .apple_valid (apple_valid),
        .eat         (eat),
        .score_bcd   (score_bcd)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    function automatic bit sq_overlap(int ax, int ay, int bx, int by);
        return (ax < bx + 10) && (bx < ax + 10) && (ay < by + 10) && (by < ay + 10);
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  cx;
        int  cy;
        bit  legal;
        cx = int'(cand_x);
        cy = int'(cand_y);
        m_eat = 1'b0;
        if (reset) begin
            m_phase = 0; m_tries = 0; m_score = 0;
            m_ax = 0; m_ay = 0; m_valid = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_score = 0; m_tries = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            legal = (cx >= 20) && (cx <= 580) && (cy >= 20) && (cy <= 440) &&
                    !sq_overlap(cx, cy, int'(head_x), int'(head_y));
            if (legal) begin
                m_ax = cx; m_ay = cy; m_valid = 1'b1; m_tries = 0; m_phase = 2;
            end else if (m_tries == 63) begin
                m_ax = 320; m_ay = 240; m_valid = 1'b1; m_tries = 0; m_phase = 2;
            end else begin
                m_tries++;
            end
        end else begin
            if (move_tick && sq_overlap(int'(head_x), int'(head_y), m_ax, m_ay)) begin
                m_eat = 1'b1; m_valid = 1'b0; m_phase = 1;
                m_score = (m_score < 9999) ? m_score + 1 : 9999;
            end
        end
    endtask

    task automatic cycle();
        @(posedge VGA_CLK);
        model_step();
        #1;
        chk("apple_x",     16'(apple_x),     16'(m_ax));
        chk("apple_y",     16'(apple_y),     16'(m_ay));
        chk("apple_valid", 16'(apple_valid), 16'(m_valid));
        chk("eat",         16'(eat),         16'(m_eat));
        chk("score",       score_bcd,        to_bcd(m_score));
    endtask

    task automatic set_cand(input int x, input int y);
        cand_x = 10'(x);
        cand_y = 10'(y);
    endtask

    task automatic set_head(input int x, input int y);
        head_x = 10'(x);
        head_y = 10'(y);
    endtask

    // Eat the live apple and re-place it at a legal spot away from the head.
    task automatic do_eat();
        set_head(m_ax, m_ay);
        if (m_ax == 100 && m_ay == 100) set_cand(300, 300);
        else                            set_cand(100, 100);
        move_tick = 1'b1;
        cycle();
        move_tick = 1'b0;
        chk("eat_pulse", 16'(eat), 16'h0001);
        cycle();
    endtask

    initial begin
        int hx;
        int hy;
        reset = 1'b1; start = 1'b0; move_tick = 1'b0;
        set_cand(0, 0); set_head(0, 0);
        m_phase = 0; m_tries = 0; m_score = 0; m_ax = 0; m_ay = 0;
        m_valid = 1'b0; m_eat = 1'b0;

        // Reset state
        cycle(); cycle();
        reset = 1'b0;
        chk("rst_valid", 16'(apple_valid), 16'h0000);
        chk("rst_score", score_bcd, 16'h0000);
        chk("rst_apple_x", 16'(apple_x), 16'h0000);
        cycle();

        // First placement
        set_cand(100, 200); set_head(300, 300);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        chk("place_x", 16'(apple_x), 16'd100);
        chk("place_y", 16'(apple_y), 16'd200);
        chk("place_valid", 16'(apple_valid), 16'h0001);
        chk("place_eat", 16'(eat), 16'h0000);

        // Eat it, then reject three candidates before accepting (120,60)
        set_head(105, 205); move_tick = 1'b1;
        cycle();
        move_tick = 1'b0;
        chk("eat1", 16'(eat), 16'h0001);
        chk("eat1_score", score_bcd, 16'h0001);
        set_head(305, 305);
        set_cand(10, 200);  cycle(); chk("rej_xlow",  16'(apple_valid), 16'h0000);
        set_cand(590, 200); cycle(); chk("rej_xhigh", 16'(apple_valid), 16'h0000);
        set_cand(300, 300); cycle(); chk("rej_head",  16'(apple_valid), 16'h0000);
        set_cand(120, 60);  cycle();
        chk("acc_x", 16'(apple_x), 16'd120);
        chk("acc_y", 16'(apple_y), 16'd60);
        chk("acc_valid", 16'(apple_valid), 16'h0001);

        // Overlap without move_tick has no effect, then with move_tick eats
        set_head(125, 65);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("no_tick_eat", 16'(eat), 16'h0000);
        end
        move_tick = 1'b1;
        cycle();
        move_tick = 1'b0;
        chk("eat2", 16'(eat), 16'h0001);
        chk("eat2_valid", 16'(apple_valid), 16'h0000);
        chk("eat2_score", score_bcd, 16'h0002);

        // Placement timeout after 64 illegal samples
        set_cand(0, 0);
        for (int i = 0; i < 63; i++) begin
            cycle();
            chk("timeout_wait", 16'(apple_valid), 16'h0000);
        end
        cycle();
        chk("fallback_x", 16'(apple_x), 16'd320);
        chk("fallback_y", 16'(apple_y), 16'd240);
        chk("fallback_valid", 16'(apple_valid), 16'h0001);

        // Reset during PLACE
        set_head(320, 240); move_tick = 1'b1;
        cycle();
        move_tick = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rstp_valid", 16'(apple_valid), 16'h0000);
        chk("rstp_score", score_bcd, 16'h0000);
        move_tick = 1'b1;
        cycle();
        move_tick = 1'b0;
        chk("idle_tick_eat", 16'(eat), 16'h0000);
        cycle();

        // Reset in the cycle after a qualifying move_tick
        set_cand(100, 200); set_head(0, 0); start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        set_head(100, 200); move_tick = 1'b1;
        cycle();
        move_tick = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rste_eat", 16'(eat), 16'h0000);
        chk("rste_score", score_bcd, 16'h0000);
        chk("rste_valid", 16'(apple_valid), 16'h0000);

        // Reset together with a qualifying move_tick
        set_head(0, 0); start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        set_head(100, 200); move_tick = 1'b1; reset = 1'b1;
        cycle();
        move_tick = 1'b0; reset = 1'b0;
        chk("rstm_eat", 16'(eat), 16'h0000);
        move_tick = 1'b1;
        cycle();
        move_tick = 1'b0;
        chk("rstm_idle_eat", 16'(eat), 16'h0000);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            start     = (m_phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            move_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) begin
                set_cand($urandom_range(0, 639), $urandom_range(0, 479));
            end else begin
                set_cand(int'(head_x) + $urandom_range(0, 16) - 8,
                         int'(head_y) + $urandom_range(0, 16) - 8);
            end
            if (m_phase == 2 && $urandom_range(0, 2) == 0) begin
                hx = m_ax + $urandom_range(0, 22) - 11;
                hy = m_ay + $urandom_range(0, 22) - 11;
                set_head((hx < 0) ? 0 : hx, (hy < 0) ? 0 : hy);
            end else begin
                set_head($urandom_range(0, 639), $urandom_range(0, 479));
            end
            cycle();
        end
        reset = 1'b0; start = 1'b0; move_tick = 1'b0;

        // Score ripple and saturation
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        set_cand(100, 100); set_head(400, 400); start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        for (int k = 1; k <= 9999; k++) begin
            do_eat();
            if (k == 9)    chk("score_0009", score_bcd, 16'h0009);
            if (k == 10)   chk("score_0010", score_bcd, 16'h0010);
            if (k == 99)   chk("score_0099", score_bcd, 16'h0099);
            if (k == 100)  chk("score_0100", score_bcd, 16'h0100);
            if (k == 999)  chk("score_0999", score_bcd, 16'h0999);
            if (k == 1000) chk("score_1000", score_bcd, 16'h1000);
        end
        chk("score_9999", score_bcd, 16'h9999);
        do_eat();
        chk("score_sat", score_bcd, 16'h9999);
        do_eat();
        chk("score_sat2", score_bcd, 16'h9999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
